ext_unit: RTL and testbench
===========================

Name: ext_unit

Overview:
- Parametrised immediate/load-data extension unit for the CPU datapath.
- Generalises the plain 16-bit sign/zero extender to eight modes: ZEXT, SEXT, LUI, LB, LBU, LH, LHU, PASS.
- Adds an alignment check and a registered, back-pressurable valid/ready output stage with a 1-entry skid buffer.
- Sits between decode/memory-read and the ALU/writeback mux.

Parameters:
- WORD_W, 32, output and load-word width; must be a multiple of 8 and at least 2*IMM_W.
- IMM_W, 16, immediate field width; also the halfword width for LH/LHU.
- BIG_ENDIAN, 0, byte/half lane order for load modes: 0 = little-endian lane numbering, 1 = big-endian.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_mode  in  3  extension mode (encodings in Behaviour).
- in_data  in  WORD_W  immediate in bits [IMM_W-1:0], or full load word for load modes.
- in_off  in  2  byte offset (address[1:0]); used only by load modes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WORD_W  extended result.
- out_misalign  out  1  result came from LH/LHU with in_off[0]=1.
- err_cnt  out  8  saturating count of misaligned requests accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_misalign=0, err_cnt=0.
  - skid buffer emptied; in_ready=1 in the following cycle.
  - Reset overrides any handshake in the same cycle; in-flight data is discarded.
- Mode encodings:
  - 0 ZEXT: zero-extend in_data[IMM_W-1:0].
  - 1 SEXT: sign-extend in_data[IMM_W-1:0] from bit IMM_W-1.
  - 2 LUI: {in_data[IMM_W-1:0], IMM_W zeros}, zero-padded to WORD_W.
  - 3 LB: byte lane in_off, sign-extended.
  - 4 LBU: byte lane in_off, zero-extended.
  - 5 LH: half lane in_off[1], sign-extended.
  - 6 LHU: half lane in_off[1], zero-extended.
  - 7 PASS: in_data unchanged.
- Lane selection:
  - BIG_ENDIAN=0: byte k = in_data[8k+7:8k]; half h = in_data[16h+15:16h].
  - BIG_ENDIAN=1: lane order reversed (byte k = in_data[WORD_W-1-8k -: 8]; halves likewise).
  - in_off is ignored in modes 0, 1, 2 and 7.
- Misalignment:
  - LH/LHU with in_off[0]=1 sets out_misalign=1 for that result.
  - out_data is still produced from half lane in_off[1]; no trap is raised here.
- Handshake:
  - Accept when in_valid && in_ready. Result appears on out_valid exactly 1 cycle after accept when not stalled.
  - Transfer out when out_valid && out_ready.
  - in_ready is a registered signal equal to !skid_full; no combinational path from out_ready to in_ready.
  - Output register empty, or draining this cycle: the accepted item is loaded into the output register.
  - Output register full and not draining: the accepted item goes to the skid buffer; in_ready drops next cycle.
  - Skid full and output drains: skid moves to the output register and in_ready rises next cycle.
  - out_data and out_misalign are held stable while out_valid && !out_ready.
  - Order is strictly FIFO; no drops, no duplicates.
- err_cnt:
  - Increments on accept of a misaligned request.
  - Saturates at 255; no wrap-around.
- Throughput: 1 result per cycle with out_ready held high.

Decomposition:
- Shared package ext_pkg holds:
  - mode localparams: EXT_ZEXT=0, EXT_SEXT=1, EXT_LUI=2, EXT_LB=3, EXT_LBU=4, EXT_LH=5, EXT_LHU=6, EXT_PASS=7;
  - the 3-bit mode typedef.
- One natural sub-module, ext_core: purely combinational mode/lane/extend logic, output data plus misalign.
- ext_unit wraps ext_core with the output register, skid buffer and err_cnt.

Test Plan:
- Reset, then send SEXT 0x0000_8001 -> out_data=0xFFFF_8001 one cycle after accept. ZEXT of the same value -> 0x0000_8001. LUI 0x0000_1234 -> 0x1234_0000.
- LB over all in_off values, in_data=0x80FF_7F01, BIG_ENDIAN=0 -> results 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80. LBU at in_off=3 -> 0x0000_0080.
- LH in_data=0x8000_1234: in_off=0 -> 0x0000_1234, misalign=0; in_off=2 -> 0xFFFF_8000; in_off=1 -> 0x0000_1234, misalign=1, err_cnt=1.
- Back-pressure: hold out_ready=0 and stream 3 requests -> 2 accepted, in_ready=0. Release out_ready -> results emerge in order, none lost; out_data stable while stalled.
- Streaming: out_ready=1, 10 back-to-back requests -> 10 results on consecutive cycles, latency 1. Assert rst mid-stream -> out_valid=0 and err_cnt=0 next cycle.
- Saturation: 300 misaligned LHU requests -> err_cnt holds at 255. Also run a BIG_ENDIAN=1 instance: LBU at in_off=0 on 0xAB00_0000 -> 0x0000_00AB.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: mode encodings and mode type shared by the extension unit and its core
package ext_pkg;
    typedef logic [2:0] ext_mode_t;
    localparam ext_mode_t EXT_ZEXT = 3'd0;
    localparam ext_mode_t EXT_SEXT = 3'd1;
    localparam ext_mode_t EXT_LUI  = 3'd2;
    localparam ext_mode_t EXT_LB   = 3'd3;
    localparam ext_mode_t EXT_LBU  = 3'd4;
    localparam ext_mode_t EXT_LH   = 3'd5;
    localparam ext_mode_t EXT_LHU  = 3'd6;
    localparam ext_mode_t EXT_PASS = 3'd7;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational mode decode, lane selection and sign/zero extension
module ext_core
    import ext_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int IMM_W      = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  ext_mode_t         mode_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [1:0]        off_i,
    output logic [WORD_W-1:0] data_o,
    output logic              misalign_o
);
    logic [7:0]       byte_l;
    logic [IMM_W-1:0] half_l;
    logic [IMM_W-1:0] imm;
    assign imm    = data_i[IMM_W-1:0];
    // Big-endian numbers lanes from the most significant end of the word
    assign byte_l = BIG_ENDIAN ? data_i[WORD_W-1-8*off_i -: 8] : data_i[8*off_i +: 8];
    assign half_l = BIG_ENDIAN ? data_i[WORD_W-1-IMM_W*off_i[1] -: IMM_W]
                               : data_i[IMM_W*off_i[1] +: IMM_W];
    assign misalign_o = (mode_i == EXT_LH || mode_i == EXT_LHU) && off_i[0];
    always_comb begin
        data_o = data_i;
        unique case (mode_i)
            EXT_ZEXT: data_o = WORD_W'(imm);
            EXT_SEXT: data_o = {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
            EXT_LUI:  data_o = WORD_W'({imm, {IMM_W{1'b0}}});
            EXT_LB:   data_o = {{(WORD_W-8){byte_l[7]}}, byte_l};
            EXT_LBU:  data_o = WORD_W'(byte_l);
            EXT_LH:   data_o = {{(WORD_W-IMM_W){half_l[IMM_W-1]}}, half_l};
            EXT_LHU:  data_o = WORD_W'(half_l);
            default:  data_o = data_i;
        endcase
    end
endmodule

// File: rtl/ext_unit.sv
// ext_unit: extension core behind a registered valid/ready output stage with a 1-entry skid buffer
module ext_unit
    import ext_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int IMM_W      = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  ext_mode_t         in_mode,
    input  logic [WORD_W-1:0] in_data,
    input  logic [1:0]        in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_misalign,
    output logic [7:0]        err_cnt
);
    logic [WORD_W-1:0] core_data;
    logic              core_mis;
    logic              out_valid_q, out_valid_d, out_mis_q, out_mis_d;
    logic [WORD_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic              skid_valid_q, skid_valid_d, skid_mis_q, skid_mis_d;
    logic [7:0]        err_q, err_d;
    logic              accept, drain;
    ext_core #(.WORD_W(WORD_W), .IMM_W(IMM_W), .BIG_ENDIAN(BIG_ENDIAN)) u_core (
        .mode_i     (in_mode),
        .data_i     (in_data),
        .off_i      (in_off),
        .data_o     (core_data),
        .misalign_o (core_mis)
    );
    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
    assign in_ready     = !skid_valid_q;
    assign accept       = in_valid && in_ready;
    assign drain        = out_valid_q && out_ready;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_misalign = out_mis_q;
    assign err_cnt      = err_q;
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mis_d    = out_mis_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mis_d   = skid_mis_q;
        if (skid_valid_q) begin
            if (drain) begin
                out_data_d   = skid_data_q;
                out_mis_d    = skid_mis_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_data_d  = core_data;
                out_mis_d   = core_mis;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = core_data;
                skid_mis_d   = core_mis;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        err_d = err_q + 8'(accept && core_mis && err_q != 8'hFF);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mis_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mis_q   <= 1'b0;
            err_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mis_q    <= out_mis_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mis_q   <= skid_mis_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_ext_unit.sv
// tb_ext_unit: directed and random checks of ext_unit against a queue-based reference model
module tb_ext_unit;
    typedef struct {
        logic [31:0] d;
        logic        m;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_misalign;
    logic [2:0]  in_mode;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_off;
    logic [7:0]  err_cnt;
    logic        b_valid, b_ready, b_out_valid, b_out_mis;
    logic [2:0]  b_mode;
    logic [31:0] b_data, b_out_data;
    logic [1:0]  b_off;
    logic [7:0]  b_err;

    int    checks = 0;
    int    errors = 0;
    int    err_m  = 0;
    item_t q[$];

    always #5 clk = ~clk;

    ext_unit #(.WORD_W(32), .IMM_W(16), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_off(in_off), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_misalign(out_misalign), .err_cnt(err_cnt)
    );

    ext_unit #(.WORD_W(32), .IMM_W(16), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_mode(b_mode),
        .in_data(b_data), .in_off(b_off), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_misalign(b_out_mis), .err_cnt(b_err)
    );

    // Reference: {misalign, data} from lane arithmetic on the whole word
    function automatic logic [32:0] ref_ext(int m, logic [31:0] d, int off, bit be);
        int          k = be ? 3 - off : off;
        int          h = be ? 1 - off / 2 : off / 2;
        logic [7:0]  b = 8'(d >> (8 * k));
        logic [15:0] hw = 16'(d >> (16 * h));
        logic [15:0] imm = d[15:0];
        logic [31:0] r;
        case (m)
            0: r = {16'h0, imm};
            1: r = int'($signed(imm));
            2: r = {imm, 16'h0};
            3: r = int'($signed(b));
            4: r = {24'h0, b};
            5: r = int'($signed(hw));
            6: r = {16'h0, hw};
            default: r = d;
        endcase
        return {(m == 5 || m == 6) && (off % 2 == 1), r};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [32:0] r;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("err_cnt", 32'(err_cnt), 32'(err_m));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_misalign", 32'(out_misalign), 32'(q[0].m));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            err_m = 0;
        end else begin
            acc = in_valid && q.size() < 2;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                r = ref_ext(int'(in_mode), in_data, int'(in_off), 1'b0);
                q.push_back('{r[31:0], r[32]});
                if (r[32] && err_m < 255) err_m++;
            end
        end
        #1;
    endtask

    task automatic send(logic [2:0] m, logic [31:0] d, logic [1:0] o);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_off   = o;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] lb_exp[4];
        logic [31:0] p[3];
        logic [32:0] r;
        lb_exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
        rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_data = '0; in_off = '0; out_ready = 1'b1;
        b_valid = 1'b0; b_mode = '0; b_data = '0; b_off = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h1);
        chk("reset_err", 32'(err_cnt), 32'h0);
        send(3'd1, 32'h0000_8001, 2'd0); chk("sext", out_data, 32'hFFFF_8001);
        send(3'd0, 32'h0000_8001, 2'd0); chk("zext", out_data, 32'h0000_8001);
        send(3'd2, 32'h0000_1234, 2'd0); chk("lui", out_data, 32'h1234_0000);
        for (int o = 0; o < 4; o++) begin
            send(3'd3, 32'h80FF_7F01, 2'(o));
            chk("lb", out_data, lb_exp[o]);
        end
        send(3'd4, 32'h80FF_7F01, 2'd3); chk("lbu3", out_data, 32'h0000_0080);
        send(3'd5, 32'h8000_1234, 2'd0); chk("lh0", out_data, 32'h0000_1234);
        chk("lh0_mis", 32'(out_misalign), 32'h0);
        send(3'd5, 32'h8000_1234, 2'd2); chk("lh2", out_data, 32'hFFFF_8000);
        send(3'd5, 32'h8000_1234, 2'd1); chk("lh1", out_data, 32'h0000_1234);
        chk("lh1_mis", 32'(out_misalign), 32'h1);
        chk("lh1_err", 32'(err_cnt), 32'h1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p[i] = $urandom;
            send(3'd7, p[i], 2'd0);
        end
        chk("bp_ready", 32'(in_ready), 32'h0);
        chk("bp_depth", 32'(q.size()), 32'd2);
        tick(); tick();
        chk("bp_hold", out_data, p[0]);
        out_ready = 1'b1;
        tick();
        chk("bp_order", out_data, p[1]);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'h0);
        for (int i = 0; i < 10; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)));
            chk("stream_valid", 32'(out_valid), 32'h1);
            in_valid = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_err", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 300; i++) send(3'd6, $urandom, 2'(2 * $urandom_range(0, 1) + 1));
        tick();
        chk("err_sat", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            in_off    = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        b_valid = 1'b1; b_mode = 3'd4; b_data = 32'hAB00_0000; b_off = 2'd0;
        tick();
        chk("be_lbu0", b_out_data, 32'h0000_00AB);
        for (int i = 0; i < 24; i++) begin
            b_mode = 3'($urandom_range(0, 7)); b_data = $urandom; b_off = 2'($urandom_range(0, 3));
            r = ref_ext(int'(b_mode), b_data, int'(b_off), 1'b1);
            tick();
            chk("be_data", b_out_data, r[31:0]);
            chk("be_mis", 32'(b_out_mis), 32'(r[32]));
        end
        b_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
